nibble_tx: RTL and testbench
============================

# nibble_tx

Serial frame transmitter: accepts a DATA_W-bit word over a valid/ready handshake and drives it onto a single-wire line as start bit, LSB-first data bits and stop bit, each held for CLKS_PER_BIT clocks. It is the send end of the team's nibble serial link. It sits downstream of the enable-gated 4-bit storage registers and provides their contents to a remote serial receiver.

## Interface
- CLKS_PER_BIT, 4, clocks per serial bit; legal range ≥1.
- DATA_W, 4, payload width in bits; legal range ≥1.

- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; 0 freezes all state, counters and tx.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  word to transmit.
- tx  output  1  serial line; idle level 1.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when the stop bit completes.

## Operation
- Reset (reset=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, in_ready=0 while reset is low, shift register=0, counters=0.
- in_ready = (state==IDLE) && en && reset. It is combinational from state and en.
- Handshake: the word is accepted on a rising edge where in_valid && in_ready. in_data is latched into the shift register. in_valid with in_ready=0 is ignored; the source holds its data.
- States:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT enabled cycles.
  - DATA → STOP after DATA_W bits.
  - STOP → IDLE after CLKS_PER_BIT enabled cycles.
- Line level by state:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx = shift_reg[0]. Shift right by one at each bit boundary. Bit 0 goes first.
  - STOP: tx=1.
- tx, busy and done are registered outputs. busy=1 in START, DATA and STOP.
- done=1 for exactly the one cycle following the STOP→IDLE edge.
- Bit timer: counts 0..CLKS_PER_BIT-1 and raises its tick when the count is CLKS_PER_BIT-1. With CLKS_PER_BIT=1 the tick is high every enabled cycle. Timer width is $clog2(CLKS_PER_BIT) bits, with a minimum of 1.
- Bit counter: counts 0..DATA_W-1 in DATA; width is $clog2(DATA_W) bits, with a minimum of 1. There is no wrap-around beyond DATA_W-1.
- en=0: state, timer, bit counter, shift register and tx all hold. done is forced to 0 and in_ready=0. The frame resumes when en returns high.
- Reset mid-frame: the frame is aborted. tx=1 immediately, done is not pulsed, and the word is discarded.

## Timing
- Handshake edge N: tx goes 0 after edge N and stays 0 for CLKS_PER_BIT cycles (all timing assumes en=1).
- Data bit k is on tx for cycles [N+(1+k)·CLKS_PER_BIT, N+(2+k)·CLKS_PER_BIT).
- Stop bit: CLKS_PER_BIT cycles.
- Return to IDLE at edge N+(DATA_W+2)·CLKS_PER_BIT. done is high for the following cycle, and in_ready is high in that same cycle.
- Back-to-back frames: the earliest next accept is at that edge, i.e. in the done cycle. The line is high for at least CLKS_PER_BIT+1 cycles between frames.
- Frame length: (DATA_W+2)·CLKS_PER_BIT cycles. With DATA_W=4 and CLKS_PER_BIT=4 this is 24 cycles.

## Structure
- Package nibble_tx_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - START_BIT=1'b0;
  - STOP_BIT=1'b1;
  - IDLE_LEVEL=1'b1.
- Sub-module bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clk, reset, en, clear;
  - output tick.
  - clear is asserted on accept so every frame starts phase-aligned.
- The top level holds the FSM, shift register, bit counter and output registers.

## Test plan
- Reset then idle: release reset with in_valid=0 → tx=1, busy=0, done=0 and in_ready=1 for 20 cycles.
- Single frame: in_data=4'b0001 with CLKS_PER_BIT=4 → tx sequence is 0,1,0,0,0,1, each level held for 4 cycles. done pulses exactly 24 cycles after the accept edge.
- Back-to-back: 4'b1111 followed by 4'b0100 with in_valid held high → the second word is accepted in the done cycle. tx is high for 5 cycles between frames, and the second frame's data bits are 0,0,1,0.
- Enable freeze: drop en for 7 cycles during data bit 2 of 4'b1110 → tx holds, done is stretched by nothing, and frame completion is delayed by exactly 7 cycles.
- Reset mid-frame: assert reset during data bit 1 of 4'b0101 → tx=1 asynchronously, no done pulse. After reset is released, 4'b1100 transmits correctly.
- CLKS_PER_BIT=1, DATA_W=4: send 4'b0111 → bits are 0,1,1,1,0,1, one per cycle. done arrives 6 cycles after accept.

Source files
------------

// File: rtl/nibble_tx_pkg.sv
// nibble_tx shared types and line levels.
// Used by the transmitter top and its bit timer.
package nibble_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_tx_bit_timer.sv
// Bit-period timer: ticks on the last clock of each serial bit.
// clear re-phases the count so a new frame starts on a bit boundary.
module bit_timer
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int TW = cnt_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == LAST);

  // count 0..LAST, wrap on tick, hold while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + TW'(1);
    end
  end

endmodule

// File: rtl/nibble_tx.sv
// Serial frame transmitter: start bit, LSB-first data, stop bit.
// Each bit is held for CLKS_PER_BIT enabled clocks.
module nibble_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              tx_n, busy_n, done_n;
  logic              accept, tick;

  assign in_ready = (state == IDLE) && en && reset;
  assign accept   = in_valid && in_ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clear(accept),
    .tick (tick)
  );

  // next state, shifter, bit count and line level
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tx_n      = tx;
    done_n    = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          tx_n = IDLE_LEVEL;
          if (accept) begin
            state_n   = START;
            shift_n   = in_data;
            bit_cnt_n = '0;
            tx_n      = START_BIT;
          end
        end
        START: begin
          if (tick) begin
            state_n = DATA;
            tx_n    = shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state_n = STOP;
              tx_n    = STOP_BIT;
            end else begin
              shift_n   = shift >> 1;
              bit_cnt_n = bit_cnt + BW'(1);
              tx_n      = shift_n[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_n = IDLE;
            tx_n    = IDLE_LEVEL;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  // state and registered outputs; reset aborts any frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_nibble_tx.sv
// nibble_tx bench: two instances (4 and 1 clocks per bit)
// compared every cycle against a frame-level reference model.
module tb_nibble_tx;

  localparam int DW  = 4;
  localparam int BUD = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst_a = '0;
  logic [1:0]    en_a  = '1;
  logic [1:0]    iv_a  = '0;
  logic [1:0]    rdy_a, tx_a, busy_a, done_a;
  logic [DW-1:0] data_a [2];

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input int ch,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s ch%0d t=%0t: got %0h expected %0h",
               tag, ch, $time, got, exp);
    end
  endtask

  // whole-frame line levels, one entry per clock
  function automatic logic [63:0] build(input int cpb,
                                        input logic [DW-1:0] d);
    logic [63:0] f;
    int b;
    f = '1;
    for (int i = 0; i < (DW + 2) * cpb; i++) begin
      b = i / cpb;
      if (b == 0) f[i] = 1'b0;
      else if (b <= DW) f[i] = d[b-1];
      else f[i] = 1'b1;
    end
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int CPB = (g == 0) ? 4 : 1;
    localparam int L   = (DW + 2) * CPB;

    nibble_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DW)
    ) dut (
      .clk     (clk),
      .reset   (rst_a[g]),
      .en      (en_a[g]),
      .in_valid(iv_a[g]),
      .in_ready(rdy_a[g]),
      .in_data (data_a[g]),
      .tx      (tx_a[g]),
      .busy    (busy_a[g]),
      .done    (done_a[g])
    );

    int          pos   = 0;
    int          len   = 0;
    logic [63:0] frame = '1;
    logic        edone = 1'b0;

    // frame-level model: position within the current frame
    always @(posedge clk or negedge rst_a[g]) begin
      if (!rst_a[g]) begin
        len   <= 0;
        pos   <= 0;
        edone <= 1'b0;
      end else if (!en_a[g]) begin
        edone <= 1'b0;
      end else if (len != 0) begin
        if (pos == len - 1) begin
          len   <= 0;
          edone <= 1'b1;
        end else begin
          pos   <= pos + 1;
          edone <= 1'b0;
        end
      end else begin
        edone <= 1'b0;
        if (iv_a[g]) begin
          frame <= build(CPB, data_a[g]);
          pos   <= 0;
          len   <= L;
        end
      end
    end

    // compare every cycle away from the active edge
    always @(negedge clk) begin
      check("tx", g, 32'(tx_a[g]),
            32'((len != 0) ? frame[pos] : 1'b1));
      check("busy", g, 32'(busy_a[g]), 32'(len != 0));
      check("done", g, 32'(done_a[g]), 32'(edone));
      check("in_ready", g, 32'(rdy_a[g]),
            32'((len == 0) && en_a[g] && rst_a[g]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // offer a word and return just after the accepting edge
  task automatic send(input int c, input logic [DW-1:0] d);
    int k;
    k = 0;
    iv_a[c]   = 1'b1;
    data_a[c] = d;
    #1;
    while (!rdy_a[c] && k < BUD) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (k >= BUD) check("accept_timeout", c, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int c);
    int k;
    k = 0;
    tick();
    while (busy_a[c] && k < BUD) begin
      tick();
      k++;
    end
    if (k >= BUD) check("idle_timeout", c, 0, 1);
    repeat (2) tick();
  endtask

  initial begin
    logic [DW-1:0] d;
    int c;
    data_a[0] = '0;
    data_a[1] = '0;
    repeat (3) tick();
    rst_a = '1;
    repeat (20) tick();

    send(0, 4'b0001);
    tick();
    iv_a[0] = 1'b0;
    wait_idle(0);

    send(0, 4'b1111);
    tick();
    send(0, 4'b0100);
    tick();
    iv_a[0] = 1'b0;
    wait_idle(0);

    send(0, 4'b1110);
    tick();
    iv_a[0] = 1'b0;
    repeat (13) tick();
    en_a[0] = 1'b0;
    repeat (7) tick();
    en_a[0] = 1'b1;
    wait_idle(0);

    send(0, 4'b0101);
    tick();
    iv_a[0] = 1'b0;
    repeat (8) tick();
    #2;
    rst_a[0] = 1'b0;
    #1;
    check("async_tx", 0, 32'(tx_a[0]), 1);
    check("async_busy", 0, 32'(busy_a[0]), 0);
    repeat (3) tick();
    rst_a[0] = 1'b1;
    repeat (2) tick();
    send(0, 4'b1100);
    tick();
    iv_a[0] = 1'b0;
    wait_idle(0);

    send(1, 4'b0111);
    tick();
    iv_a[1] = 1'b0;
    wait_idle(1);

    repeat (40) begin
      c = $urandom_range(0, 1);
      d = DW'($urandom);
      send(c, d);
      tick();
      iv_a[c] = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 10)) tick();
        en_a[c] = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        en_a[c] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        tick();
        iv_a[c]   = 1'b1;
        data_a[c] = ~d;
        tick();
        iv_a[c] = 1'b0;
      end
      wait_idle(c);
      wait_idle(c);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
